ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder_pkg.sv | 53 +++++
 rtl/ps2_key_decoder_if.sv | 27 ++
 rtl/ps2_frame_rx.sv | 108 ++++++++++
 rtl/ps2_key_decoder.sv | 116 +++++++++++
 tb/tb_ps2_key_decoder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder and the game logic behind it:
// game key codes, protocol prefix bytes, decoder states and the scan-code map.
package ps2_key_decoder_pkg;

  localparam logic [4:0] KEY_NONE    = 5'd0;
  localparam logic [4:0] KEY_UP      = 5'd1;
  localparam logic [4:0] KEY_DOWN    = 5'd2;
  localparam logic [4:0] KEY_LEFT    = 5'd3;
  localparam logic [4:0] KEY_RIGHT   = 5'd4;
  localparam logic [4:0] KEY_UNDO    = 5'd5;
  localparam logic [4:0] KEY_RESTART = 5'd6;
  localparam logic [4:0] KEY_ENTER   = 5'd7;
  localparam logic [4:0] KEY_ESC     = 5'd8;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Unlisted scan codes map to KEY_NONE so callers can treat them as "ignore".
  function automatic logic [4:0] map_scan(input logic [7:0] sc, input logic ext);
    logic [4:0] code;
    code = KEY_NONE;
    if (ext) begin
      case (sc)
        8'h75:   code = KEY_UP;
        8'h72:   code = KEY_DOWN;
        8'h6B:   code = KEY_LEFT;
        8'h74:   code = KEY_RIGHT;
        default: code = KEY_NONE;
      endcase
    end else begin
      case (sc)
        8'h1D:   code = KEY_UP;
        8'h1B:   code = KEY_DOWN;
        8'h1C:   code = KEY_LEFT;
        8'h23:   code = KEY_RIGHT;
        8'h1A:   code = KEY_UNDO;
        8'h2D:   code = KEY_RESTART;
        8'h5A:   code = KEY_ENTER;
        8'h76:   code = KEY_ESC;
        default: code = KEY_NONE;
      endcase
    end
    return code;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the raw PS/2 lines and the decoded key outputs; the decoder is the
// slave, whoever drives the keyboard lines and consumes the key is the master.
interface ps2_key_decoder_if;

  logic       ps2Clk;
  logic       ps2Data;
  logic       keyReady;
  logic [4:0] keyCode;
  logic       frameErr;

  modport master (
    output ps2Clk,
    output ps2Data,
    input  keyReady,
    input  keyCode,
    input  frameErr
  );

  modport slave (
    input  ps2Clk,
    input  ps2Data,
    output keyReady,
    output keyCode,
    output frameErr
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes and debounces the raw lines, shifts in
// 11-bit frames on filtered falling edges and flags parity/stop/timeout errors.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;

  // Idle-high lines reset to 1 so leaving reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FILT_MAX) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
          fall     <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // bit_cnt: 0 waits for start, 1..8 data LSB first, 9 parity, 10 stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!data_sync[1]) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shreg   <= {data_sync[1], shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          parity_bit <= data_sync[1];
          bit_cnt    <= 4'd10;
        end else begin
          bit_cnt <= '0;
          if (data_sync[1] && (^{shreg, parity_bit}))
            byte_valid <= 1'b1;
          else
            frame_err <= 1'b1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (tmo_cnt == TMO_MAX) begin
          bit_cnt   <= '0;
          tmo_cnt   <= '0;
          frame_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/ps2_key_decoder.sv
// Turns PS/2 make/break/extended byte sequences into a held game key code,
// guaranteeing one fresh keyReady rising edge per newly pressed mapped key.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              clk,
  input logic              rst,
  ps2_key_decoder_if.slave bus
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  dec_state_t state;
  dec_state_t state_next;
  logic       ev_make;
  logic       ev_break;
  logic [4:0] ev_code;

  logic       key_ready;
  logic [4:0] key_code;
  logic       pend_valid;
  logic [4:0] pend_code;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (bus.ps2Clk),
    .ps2_data   (bus.ps2Data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ev_make    = 1'b0;
    ev_break   = 1'b0;
    ev_code    = KEY_NONE;
    if (frame_err) begin
      state_next = ST_IDLE;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_byte == SC_EXT)      state_next = ST_EXT;
          else if (rx_byte == SC_BRK) state_next = ST_BRK;
          else begin
            ev_make = 1'b1;
            ev_code = map_scan(rx_byte, 1'b0);
          end
        end
        ST_EXT: begin
          if (rx_byte == SC_BRK) state_next = ST_EXT_BRK;
          else begin
            ev_make    = 1'b1;
            ev_code    = map_scan(rx_byte, 1'b1);
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_break   = 1'b1;
          ev_code    = map_scan(rx_byte, 1'b0);
          state_next = ST_IDLE;
        end
        default: begin
          ev_break   = 1'b1;
          ev_code    = map_scan(rx_byte, 1'b1);
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // A switch to a different key drops keyReady for one cycle so the consumer
  // sees a new rising edge; the incoming code waits in pend_code meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_ready  <= 1'b0;
      key_code   <= KEY_NONE;
      pend_valid <= 1'b0;
      pend_code  <= KEY_NONE;
    end else if (pend_valid) begin
      key_code   <= pend_code;
      key_ready  <= 1'b1;
      pend_valid <= 1'b0;
    end else if (ev_make && ev_code != KEY_NONE) begin
      if (!key_ready) begin
        key_code  <= ev_code;
        key_ready <= 1'b1;
      end else if (ev_code != key_code) begin
        key_ready  <= 1'b0;
        pend_code  <= ev_code;
        pend_valid <= 1'b1;
      end
    end else if (ev_break && ev_code != KEY_NONE && key_ready && ev_code == key_code) begin
      key_ready <= 1'b0;
    end
  end

  assign bus.keyReady = key_ready;
  assign bus.keyCode  = key_code;
  assign bus.frameErr = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives bit-level PS/2 frames and checks
// key events, the keyReady edge discipline, frame errors and reset behaviour.
module tb_ps2_key_decoder;

  localparam int HALF    = 12;
  localparam int TIMEOUT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   nChecks  = 0;
  int   nFail    = 0;
  int   riseCount = 0;
  int   errCount  = 0;
  int   lowRun    = 0;
  int   lastGap   = 0;
  logic prevReady = 1'b0;

  // Edge/pulse monitor sampled on the falling clock edge.
  always @(negedge clk) begin
    if (bus.frameErr === 1'b1) errCount <= errCount + 1;
    if (bus.keyReady === 1'b1) begin
      if (!prevReady) begin
        riseCount <= riseCount + 1;
        lastGap   <= lowRun;
      end
      lowRun <= 0;
    end else begin
      lowRun <= lowRun + 1;
    end
    prevReady <= (bus.keyReady === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic ps2Fall(input logic b);
    @(posedge clk); #1 bus.ps2Data = b;
    repeat (HALF) @(posedge clk);
    #1 bus.ps2Clk = 1'b0;
  endtask

  task automatic ps2Rise();
    repeat (HALF) @(posedge clk);
    #1 bus.ps2Clk = 1'b1;
  endtask

  // Everything up to and including the stop-bit falling edge; ps2Clk left low.
  task automatic sendHead(input logic [7:0] b, input logic goodParity);
    logic par;
    par = goodParity ? ~(^b) : (^b);
    ps2Fall(1'b0); ps2Rise();
    for (int i = 0; i < 8; i++) begin
      ps2Fall(b[i]); ps2Rise();
    end
    ps2Fall(par); ps2Rise();
    ps2Fall(1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic goodParity);
    sendHead(b, goodParity);
    ps2Rise();
    repeat (4) @(posedge clk);
  endtask

  task automatic sendPartial(input int nBits);
    ps2Fall(1'b0); ps2Rise();
    for (int i = 1; i < nBits; i++) begin
      ps2Fall(1'b1); ps2Rise();
    end
  endtask

  initial begin
    int r0;
    int e0;
    bus.ps2Clk  = 1'b1;
    bus.ps2Data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(bus.keyReady), 32'd0);
    checkOutput("reset_code",  32'(bus.keyCode),  32'd0);
    checkOutput("reset_err",   32'(bus.frameErr), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    $display("[TB] make/break of W with latency check");
    r0 = riseCount;
    sendHead(8'h1D, 1'b1);
    repeat (11) @(posedge clk);
    #1 checkOutput("lat_early", 32'(bus.keyReady), 32'd0);
    @(posedge clk);
    #1 checkOutput("lat_rise", 32'(bus.keyReady), 32'd1);
    checkOutput("w_code", 32'(bus.keyCode), 32'd1);
    ps2Rise();
    repeat (4) @(posedge clk);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h1D, 1'b1);
    #1 checkOutput("w_break_ready", 32'(bus.keyReady), 32'd0);
    checkOutput("w_break_code", 32'(bus.keyCode), 32'd1);
    checkOutput("w_rises", 32'(riseCount - r0), 32'd1);

    $display("[TB] unmapped make");
    applyStimulus(8'h15, 1'b1);
    #1 checkOutput("unmapped_ready", 32'(bus.keyReady), 32'd0);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h15, 1'b1);

    $display("[TB] extended right arrow");
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'h74, 1'b1);
    #1 checkOutput("ext_ready", 32'(bus.keyReady), 32'd1);
    checkOutput("ext_code", 32'(bus.keyCode), 32'd4);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h74, 1'b1);
    #1 checkOutput("ext_break", 32'(bus.keyReady), 32'd0);
    r0 = riseCount;
    applyStimulus(8'h74, 1'b1);
    #1 checkOutput("plain74_ready", 32'(bus.keyReady), 32'd0);
    checkOutput("plain74_rises", 32'(riseCount - r0), 32'd0);

    $display("[TB] typematic repeat and key switch");
    r0 = riseCount;
    applyStimulus(8'h1C, 1'b1);
    applyStimulus(8'h1C, 1'b1);
    applyStimulus(8'h1C, 1'b1);
    #1 checkOutput("a_code", 32'(bus.keyCode), 32'd3);
    checkOutput("a_rises", 32'(riseCount - r0), 32'd1);
    applyStimulus(8'h23, 1'b1);
    #1 checkOutput("d_code", 32'(bus.keyCode), 32'd4);
    checkOutput("d_ready", 32'(bus.keyReady), 32'd1);
    checkOutput("d_rises", 32'(riseCount - r0), 32'd2);
    checkOutput("d_gap", 32'(lastGap), 32'd1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h1C, 1'b1);
    #1 checkOutput("nonheld_break", 32'(bus.keyReady), 32'd1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h23, 1'b1);
    #1 checkOutput("d_break", 32'(bus.keyReady), 32'd0);

    $display("[TB] parity error");
    e0 = errCount;
    applyStimulus(8'h1D, 1'b0);
    #1 checkOutput("par_err", 32'(errCount - e0), 32'd1);
    checkOutput("par_ready", 32'(bus.keyReady), 32'd0);
    applyStimulus(8'h1D, 1'b1);
    #1 checkOutput("par_recover", 32'(bus.keyReady), 32'd1);
    checkOutput("par_recover_code", 32'(bus.keyCode), 32'd1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h1D, 1'b1);

    $display("[TB] timeout");
    e0 = errCount;
    sendPartial(4);
    repeat (TIMEOUT - 100) @(posedge clk);
    #1 checkOutput("tmo_early", 32'(errCount - e0), 32'd0);
    repeat (200) @(posedge clk);
    #1 checkOutput("tmo_err", 32'(errCount - e0), 32'd1);
    applyStimulus(8'h5A, 1'b1);
    #1 checkOutput("tmo_recover", 32'(bus.keyCode), 32'd7);
    checkOutput("tmo_recover_ready", 32'(bus.keyReady), 32'd1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h5A, 1'b1);

    $display("[TB] reset while held and mid-frame");
    applyStimulus(8'h76, 1'b1);
    #1 checkOutput("esc_code", 32'(bus.keyCode), 32'd8);
    sendPartial(4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ready", 32'(bus.keyReady), 32'd0);
    checkOutput("rst_code",  32'(bus.keyCode),  32'd0);
    checkOutput("rst_err",   32'(bus.frameErr), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    e0 = errCount;
    applyStimulus(8'h2D, 1'b1);
    #1 checkOutput("post_rst_code", 32'(bus.keyCode), 32'd6);
    checkOutput("post_rst_ready", 32'(bus.keyReady), 32'd1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h2D, 1'b1);

    $display("[TB] short ps2Clk glitch");
    @(posedge clk); #1 bus.ps2Data = 1'b0;
    @(posedge clk); #1 bus.ps2Clk = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.ps2Clk = 1'b1;
    repeat (20) @(posedge clk);
    applyStimulus(8'h1A, 1'b1);
    #1 checkOutput("glitch_code", 32'(bus.keyCode), 32'd5);
    checkOutput("glitch_ready", 32'(bus.keyReady), 32'd1);
    checkOutput("glitch_err", 32'(errCount - e0), 32'd0);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h1A, 1'b1);
    #1 checkOutput("final_break", 32'(bus.keyReady), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
